// File: rtl/dsram_responder.sv
// Responder side of the CPU data-SRAM request interface: a byte-enabled word memory
// plus an in-order response queue that returns each transaction after LATENCY cycles.

module dsram_responder_slot #(
  parameter int TW      = 1,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          wr_in,
  input  logic [31:0]   data_in,
  output logic          vld,
  output logic          wr,
  output logic [31:0]   data,
  output logic [TW-1:0] timer
);
  // A push on a slot being popped in the same edge (full queue) reloads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= 1'b0;
      wr    <= 1'b0;
      data  <= 32'h0;
      timer <= '0;
    end else if (push) begin
      vld   <= 1'b1;
      wr    <= wr_in;
      data  <= data_in;
      timer <= TW'(LATENCY - 1);
    end else begin
      if (pop) vld <= 1'b0;
      if (vld && timer != '0) timer <= timer - 1'b1;
    end
  end
endmodule

module dsram_responder #(
  parameter int AW      = 14,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [31:0] mem [2**AW];
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          push, pop;

  logic [DEPTH-1:0]          slot_vld, slot_wr;
  logic [DEPTH-1:0][31:0]    slot_data;
  logic [DEPTH-1:0][TW-1:0]  slot_tmr;

  assign idx     = addr[AW+1:2];
  assign rd_word = wr ? 32'h0 : mem[idx];

  // Outputs depend only on queue state, rst and stall; a same-cycle pop frees a slot.
  assign data_ok = ~rst & slot_vld[head] & (slot_tmr[head] == '0);
  assign pop     = data_ok;
  assign addr_ok = ~rst & ~stall & ((count < DEPTH_C) | data_ok);
  assign push    = req & addr_ok;
  assign rdata   = (data_ok & ~slot_wr[head]) ? slot_data[head] : 32'h0;

  always_ff @(posedge clk) begin
    if (push & wr)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= (tail == LAST_P) ? '0 : tail + 1'b1;
      if (pop)  head <= (head == LAST_P) ? '0 : head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    dsram_responder_slot #(.TW(TW), .LATENCY(LATENCY)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .push    (push && tail == PW'(g)),
      .pop     (pop && head == PW'(g)),
      .wr_in   (wr),
      .data_in (rd_word),
      .vld     (slot_vld[g]),
      .wr      (slot_wr[g]),
      .data    (slot_data[g]),
      .timer   (slot_tmr[g])
    );
  end
endmodule

// File: tb/tb_dsram_responder.sv
// Scoreboard bench for dsram_responder: driver issues requests, a negedge monitor checks
// acceptance, response timing and data against a word/byte-mask memory model.

module tb_dsram_responder;
  localparam int AW = 14, LAT = 3, DEP = 2;

  logic        clk = 0, rst = 1, req = 0, wr = 0, stall = 0;
  logic [3:0]  wstrb = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  dsram_responder #(.AW(AW), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .stall(stall), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] exp;
    logic [31:0] mask;
  } resp_t;

  resp_t       sbq[$];
  logic [31:0] mmem   [int];
  logic [31:0] mknown [int];
  int cyc = 0, n_chk = 0, n_fail = 0;
  bit en_rs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp, input logic [31:0] msk);
    n_chk++;
    if (((act ^ exp) & msk) !== 32'h0) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (mask %h) cycle %0d", nm, act, exp, msk, cyc);
    end
  endfunction

  // Monitor: model of outstanding responses, each due LAT cycles after its accept.
  always @(negedge clk) begin
    resp_t r;
    int    key;
    logic  exp_ok;
    if (rst) begin
      chk("rst_addr_ok", addr_ok, 0, 1);
      chk("rst_data_ok", data_ok, 0, 1);
      chk("rst_rdata", rdata, 0, '1);
      sbq.delete();
    end else begin
      exp_ok = !stall && (sbq.size() < DEP || (sbq.size() > 0 && sbq[0].due == cyc));
      chk("addr_ok", addr_ok, exp_ok, 1);
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
        chk("late_resp", 0, 1, 1);
        void'(sbq.pop_front());
      end
      if (data_ok) begin
        if (sbq.size() == 0) chk("spurious_data_ok", 1, 0, 1);
        else begin
          r = sbq.pop_front();
          chk("resp_cycle", cyc, r.due, '1);
          chk("rdata", rdata, r.exp, r.mask);
        end
      end else chk("rdata_idle", rdata, 0, '1);
      if (req && addr_ok) begin
        key   = int'((addr >> 2) % (1 << AW));
        r.due = cyc + LAT;
        if (!mmem.exists(key)) begin mmem[key] = 0; mknown[key] = 0; end
        if (wr) begin
          r.exp = 0; r.mask = '1;
          for (int b = 0; b < 4; b++)
            if (wstrb[b]) begin
              mmem[key][8*b +: 8]   = wdata[8*b +: 8];
              mknown[key][8*b +: 8] = 8'hFF;
            end
        end else begin
          r.exp = mmem[key]; r.mask = mknown[key];
        end
        sbq.push_back(r);
      end
    end
  end

  task automatic send(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    bit got = 0;
    req = 1; wr = w; wstrb = s; addr = a; wdata = d;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (addr_ok) begin got = 1; break; end
    end
    chk("accept_timeout", got, 1, 1);
    @(posedge clk); #1;
    req = 0; wr = 0; wstrb = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sbq.size() > 0; k++) @(posedge clk);
    #1;
    chk("drain", sbq.size(), 0, '1);
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (en_rs) stall = ($urandom_range(0, 5) == 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle(3); rst = 0;
    // write then read, byte merge, no-op write
    send(1, 4'b1111, 32'h100, 32'h12345678);
    send(0, 4'b0000, 32'h100, 32'h0);
    send(1, 4'b0100, 32'h102, 32'h00AB0000);
    send(0, 4'b0000, 32'h100, 32'h0);
    send(1, 4'b1100, 32'h100, 32'hCDEF0000);
    send(0, 4'b0000, 32'h100, 32'h0);
    send(1, 4'b0000, 32'h100, 32'hFFFFFFFF);
    send(0, 4'b0000, 32'h100, 32'h0);
    drain();
    // back-to-back reads: DEPTH < LATENCY so the queue fills
    for (int i = 0; i < 4; i++) send(0, 4'b0000, 32'h100 + 32'(4*i), 32'h0);
    drain();
    // stall held 3 cycles with req high
    stall = 1;
    fork
      send(0, 4'b0000, 32'h100, 32'h0);
      begin idle(3); stall = 0; end
    join
    // address wrap at 2^(AW+2)
    send(1, 4'b1111, 32'h10000, 32'hA5A51234);
    send(0, 4'b0000, 32'h0, 32'h0);
    drain();
    // reset mid-flight
    send(1, 4'b1111, 32'h200, 32'hDEADBEEF);
    send(0, 4'b0000, 32'h200, 32'h0);
    rst = 1;
    idle(2);
    rst = 0;
    idle(LAT + 2);
    send(0, 4'b0000, 32'h200, 32'h0);
    drain();
    // randomized traffic with random stall
    en_rs = 1;
    for (int i = 0; i < 300; i++) begin
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           (32'($urandom_range(0, 3)) << 16) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)),
           $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    en_rs = 0;
    idle(1);
    stall = 0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dsram_responder.md
# dsram_responder

Responder end of the CPU data-SRAM request interface. It accepts requests issued by the memory stage, commits byte-enabled writes to a local word-addressed memory, and returns in-order responses after a fixed, parameterised latency. Up to DEPTH transactions can be outstanding. It serves as the data-memory model for core simulation and as the target side of the data bus once the core moves to a split request/response protocol.

## Interface
- AW, 14: word-index width; the memory holds 2^AW 32-bit words.
- LATENCY, 2: number of cycles from the request-accept edge to `data_ok`; must be ≥1.
- DEPTH, 2: maximum number of outstanding transactions; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  1  request valid
- wr  in  1  1 = write, 0 = read
- wstrb  in  4  byte write enables; ignored when wr=0
- addr  in  32  byte address; bits [1:0] ignored
- wdata  in  32  write data, byte lanes aligned to the word
- stall  in  1  test hook; forces addr_ok low
- addr_ok  out  1  request accepted this cycle when req is also high
- data_ok  out  1  response valid, one cycle per transaction
- rdata  out  32  read data, valid while data_ok is high

## Operation
- Accept condition: `req & addr_ok`. addr_ok is `~rst & ~stall & (count < DEPTH | data_ok)`. It does not depend on req, and a pop in the same cycle frees a slot.
- Index is `addr[AW+1:2]`. Upper address bits are ignored, so addresses wrap modulo 2^(AW+2).
- Write: on the accept edge, byte i of `mem[index]` takes `wdata[8i+7:8i]` for each set `wstrb[i]`. wstrb=0000 is a legal no-op write that still gets a response.
- Read: on the accept edge, `mem[index]` is sampled into the queue entry. A read therefore sees every write accepted before it, and is not affected by writes accepted after it.
- Queue: circular buffer of DEPTH entries, each holding {wr, data, timer}. Head and tail pointers wrap at DEPTH. count is in the range 0..DEPTH.
- On push, the entry's timer is set to LATENCY-1. Every cycle, each valid entry with a nonzero timer decrements by 1.
- `data_ok = head_valid & head_timer==0`. The pop happens on the same edge. Responses are strictly in acceptance order.
- rdata is the head entry's data for reads and 32'h0 for writes. rdata is 32'h0 whenever data_ok is low.
- If the head is not ready, younger entries keep decrementing down to 0. They pop on consecutive cycles once they reach the head.
- Memory contents are not cleared by reset. Any value read before the first write to that word is X.
- Reset: queue is flushed (count=0, pointers=0). Outputs: addr_ok=0, data_ok=0, rdata=0.
- Reset mid-flight: pending responses are dropped and never produce data_ok. Writes already accepted stay committed.

## Timing
- Accept at edge t → data_ok is high in the LATENCY-th cycle after t. With LATENCY=1, that is the cycle immediately after acceptance.
- Throughput is one transaction per cycle when DEPTH ≥ LATENCY. Otherwise it is DEPTH transactions per LATENCY cycles.
- Full queue (count=DEPTH, no pop): addr_ok=0. The requester must hold req and its payload until acceptance.
- Full queue with a pop this cycle: addr_ok=1. Push and pop occur on the same edge and count is unchanged.
- stall: addr_ok drops in the same cycle. Responses already queued still complete on schedule.
- First cycle after rst falls: addr_ok=1 unless stall is high.
- All outputs are derived from registers plus the rst and stall inputs. There is no combinational path from req, addr, or wdata to any output.

## Test plan
- LATENCY=2: write 0x12345678 to 0x100 with wstrb=1111, then read 0x100 → the write's data_ok comes 2 cycles after its accept with rdata=0; the read's data_ok comes 2 cycles after its accept with rdata=0x12345678.
- Byte merge: after the test above, write wdata=0x00AB0000 to 0x102 with wstrb=0100, then read 0x100 → rdata=0x12AB5678. Then write wdata=0xCDEF0000 to 0x100 with wstrb=1100 and read again → 0xCDEF5678.
- Back-to-back, DEPTH=2, LATENCY=2: four reads issued on consecutive cycles with req held high → addr_ok stays high every cycle; data_ok is high 4 consecutive cycles in order, starting 2 cycles after the first accept.
- Full queue, DEPTH=2, LATENCY=4: three reads in a row → the first two are accepted; the third sees addr_ok=0 until the cycle the first data_ok fires and is accepted in that cycle; responses come out in order.
- Stall and wrap, AW=14: with stall=1 for 3 cycles and req high → no accept; accepted the cycle stall falls. A write to 0x10000 followed by a read of 0x0 → the read returns the written data (wrap).
- Reset mid-flight, LATENCY=4: write then read of 0x200, assert rst one cycle after the read is accepted → no data_ok appears; after reset, a read of 0x200 returns the written value.
